// File: rtl/ser_fifo.sv
// Bus-attached UART receiver with a 2**DEPTH_LOG2-byte RX FIFO and sticky error flags.
// Optional transmitter enabled by defining SER_TX_EN; otherwise txd idles high.
module ser_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       wr,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       rxd,
  output logic       txd
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       r_rx_state, w_rx_next;
  logic            r_rx_s1, r_rx_s2;
  logic [CW-1:0]   r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift;
  logic            w_rx_cnt_clr, w_rx_bit_clr, w_rx_shift_en, w_rx_push, w_rx_ferr;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ovr, r_ferr;
  logic                  w_full, w_empty, w_pop, w_push, w_ovr_set, w_reg_clr, w_tx_ready;
  logic [15:0]           w_cnt_ext;
  logic                  w_unused;

  // rxd is asynchronous; reset the synchronizer to the idle level
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rxd;
      r_rx_s2 <= r_rx_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_rx_state <= RX_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next     = r_rx_state;
    w_rx_cnt_clr  = 1'b0;
    w_rx_bit_clr  = 1'b0;
    w_rx_shift_en = 1'b0;
    w_rx_push     = 1'b0;
    w_rx_ferr     = 1'b0;
    case (r_rx_state)
      RX_IDLE: if (!r_rx_s2) begin
        w_rx_next    = RX_START;
        w_rx_cnt_clr = 1'b1;
        w_rx_bit_clr = 1'b1;
      end
      RX_START: if (r_rx_cnt == C_HALF) begin
        w_rx_cnt_clr = 1'b1;
        w_rx_next    = r_rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (r_rx_cnt == C_FULL) begin
        w_rx_cnt_clr  = 1'b1;
        w_rx_shift_en = 1'b1;
        if (r_rx_bit == 3'd7) w_rx_next = RX_STOP;
      end
      RX_STOP: if (r_rx_cnt == C_FULL) begin
        w_rx_cnt_clr = 1'b1;
        w_rx_next    = RX_IDLE;
        w_rx_push    = r_rx_s2;
        w_rx_ferr    = ~r_rx_s2;
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_cnt <= w_rx_cnt_clr ? '0 : r_rx_cnt + CW'(1);
      if (w_rx_bit_clr) begin
        r_rx_bit <= '0;
      end else if (w_rx_shift_en) begin
        r_rx_bit   <= r_rx_bit + 3'd1;
        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
      end
    end
  end

  // A pop on the same edge frees a slot, so a push into a full FIFO still lands
  assign w_full    = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = en & ~wr & (addr == 2'd1) & ~w_empty;
  assign w_push    = w_rx_push & (~w_full | w_pop);
  assign w_ovr_set = w_rx_push & w_full & ~w_pop;
  assign w_reg_clr = en & wr & (addr == 2'd3);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_rx_shift;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovr    <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_ovr  <= w_ovr_set | (r_ovr  & ~(w_reg_clr & data_in[1]));
      r_ferr <= w_rx_ferr | (r_ferr & ~(w_reg_clr & data_in[0]));
    end
  end

`ifdef SER_TX_EN
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t     r_tx_state, w_tx_next;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          r_txd;
  logic          w_tx_load, w_tx_end, w_tx_cnt_clr;

  assign w_tx_ready = (r_tx_state == TX_IDLE);
  assign w_tx_load  = en & wr & (addr == 2'd2) & w_tx_ready;
  assign w_tx_end   = (r_tx_cnt == C_FULL);
  assign txd        = r_txd;

  always_ff @(posedge clk) begin
    if (!reset) r_tx_state <= TX_IDLE;
    else        r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next    = r_tx_state;
    w_tx_cnt_clr = 1'b0;
    case (r_tx_state)
      TX_IDLE:  if (w_tx_load) begin w_tx_next = TX_START; w_tx_cnt_clr = 1'b1; end
      TX_START: if (w_tx_end)  begin w_tx_next = TX_DATA;  w_tx_cnt_clr = 1'b1; end
      TX_DATA:  if (w_tx_end) begin
        w_tx_cnt_clr = 1'b1;
        if (r_tx_bit == 3'd7) w_tx_next = TX_STOP;
      end
      TX_STOP:  if (w_tx_end)  begin w_tx_next = TX_IDLE;  w_tx_cnt_clr = 1'b1; end
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  // txd is loaded one bit ahead so each level starts on the edge that ends the previous bit
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_tx_cnt <= w_tx_cnt_clr ? '0 : r_tx_cnt + CW'(1);
      case (r_tx_state)
        TX_IDLE: begin
          r_txd <= ~w_tx_load;
          if (w_tx_load) begin
            r_tx_shift <= data_in;
            r_tx_bit   <= '0;
          end
        end
        TX_START: if (w_tx_end) r_txd <= r_tx_shift[0];
        TX_DATA: if (w_tx_end) begin
          r_tx_bit <= r_tx_bit + 3'd1;
          if (r_tx_bit == 3'd7) begin
            r_txd <= 1'b1;
          end else begin
            r_txd      <= r_tx_shift[1];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          end
        end
        default: r_txd <= 1'b1;
      endcase
    end
  end
`else
  assign w_tx_ready = 1'b0;
  assign txd        = 1'b1;
`endif

  assign w_cnt_ext = 16'(r_count);
  assign w_unused  = ^{data_in[7:2], w_cnt_ext[15:8]};

  always_comb begin
    data_out = 8'h00;
    case (addr)
      2'd0:    data_out = {4'b0, r_ovr, r_ferr, w_tx_ready, ~w_empty};
      2'd1:    data_out = w_empty ? 8'h00 : r_mem[r_rd_ptr];
      2'd3:    data_out = w_cnt_ext[7:0];
      default: data_out = 8'h00;
    endcase
  end

endmodule
